// File: rtl/operand_fetch.sv
// Operand fetch stage: register file with write-through bypass feeding a
// single-entry output register with valid/stall/flush control.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              inValid,
    output logic              inReady,
    input  logic [REG_AW-1:0] rsAddr,
    input  logic [REG_AW-1:0] rtAddr,
    input  logic [DATA_W-1:0] immVal,
    input  logic              useImm,
    input  logic [2:0]        aluControlIn,
    input  logic [REG_AW-1:0] destAddrIn,
    input  logic              regWriteIn,
    input  logic              wbEn,
    input  logic [REG_AW-1:0] wbAddr,
    input  logic [DATA_W-1:0] wbData,
    input  logic              stall,
    input  logic              flush,
    output logic              outValid,
    output logic [DATA_W-1:0] srcA,
    output logic [DATA_W-1:0] srcB,
    output logic [2:0]        aluControl,
    output logic [REG_AW-1:0] destAddr,
    output logic              regWrite
);

    localparam int DEPTH = 2 ** REG_AW;

    logic [DATA_W-1:0] regFile [DEPTH];
    logic              wbHit;
    logic [DATA_W-1:0] readA;
    logic [DATA_W-1:0] readB;

    assign wbHit   = wbEn && (wbAddr != '0);
    assign inReady = !stall || !outValid;

    // r0 is hard-wired to zero; a matching writeback bypasses the array
    always_comb begin
        readA = regFile[rsAddr];
        if (rsAddr == '0) begin
            readA = '0;
        end else if (wbHit && (wbAddr == rsAddr)) begin
            readA = wbData;
        end
    end

    always_comb begin
        readB = regFile[rtAddr];
        if (useImm) begin
            readB = immVal;
        end else if (rtAddr == '0) begin
            readB = '0;
        end else if (wbHit && (wbAddr == rtAddr)) begin
            readB = wbData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                regFile[i] <= '0;
            end
        end else if (wbHit) begin
            regFile[wbAddr] <= wbData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            outValid   <= 1'b0;
            srcA       <= '0;
            srcB       <= '0;
            aluControl <= '0;
            destAddr   <= '0;
            regWrite   <= 1'b0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (inReady) begin
            outValid <= inValid;
            if (inValid) begin
                srcA       <= readA;
                srcB       <= readB;
                aluControl <= aluControlIn;
                destAddr   <= destAddrIn;
                regWrite   <= regWriteIn;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table followed by random
// traffic compared against a behavioural model.
module tb_operand_fetch;

    logic        clk;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [4:0]  rsAddr;
    logic [4:0]  rtAddr;
    logic [31:0] immVal;
    logic        useImm;
    logic [2:0]  aluControlIn;
    logic [4:0]  destAddrIn;
    logic        regWriteIn;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        stall;
    logic        flush;
    logic        outValid;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [2:0]  aluControl;
    logic [4:0]  destAddr;
    logic        regWrite;

    int total = 0;
    int bad = 0;

    operand_fetch #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
        .rsAddr(rsAddr), .rtAddr(rtAddr), .immVal(immVal), .useImm(useImm),
        .aluControlIn(aluControlIn), .destAddrIn(destAddrIn),
        .regWriteIn(regWriteIn), .wbEn(wbEn), .wbAddr(wbAddr),
        .wbData(wbData), .stall(stall), .flush(flush),
        .outValid(outValid), .srcA(srcA), .srcB(srcB),
        .aluControl(aluControl), .destAddr(destAddr), .regWrite(regWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rstN;
        logic        inV;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        useI;
        logic [31:0] imm;
        logic [2:0]  alu;
        logic [4:0]  dest;
        logic        rw;
        logic        wbE;
        logic [4:0]  wbA;
        logic [31:0] wbD;
        logic        st;
        logic        fl;
        logic        eRdy;
        logic        eVal;
        logic        chkD;
        logic [31:0] eA;
        logic [31:0] eB;
        logic [2:0]  eAlu;
        logic [4:0]  eDest;
        logic        eRw;
    } vec_t;

    vec_t vecs[$];

    // behavioural model state
    logic [31:0] mRegs [32];
    logic        mValid = 1'b0;
    logic        mKnown = 1'b0;
    logic [31:0] mA, mB;
    logic [2:0]  mAlu;
    logic [4:0]  mDest;
    logic        mRw;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] rdModel(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wbEn && wbAddr != 5'd0 && wbAddr == a) return wbData;
        return mRegs[a];
    endfunction

    task automatic modelStep();
        logic [31:0] ra, rb;
        if (!rstN) begin
            for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
            mValid = 1'b0;
            mKnown = 1'b1;
            mA = 0; mB = 0; mAlu = 0; mDest = 0; mRw = 0;
        end else begin
            ra = rdModel(rsAddr);
            rb = useImm ? immVal : rdModel(rtAddr);
            if (flush) begin
                mValid = 1'b0;
                mKnown = 1'b0;
            end else if (!stall || !mValid) begin
                mValid = inValid;
                mKnown = inValid;
                if (inValid) begin
                    mA = ra; mB = rb; mAlu = aluControlIn;
                    mDest = destAddrIn; mRw = regWriteIn;
                end
            end
            if (wbEn && wbAddr != 5'd0) mRegs[wbAddr] = wbData;
        end
    endtask

    task automatic apply(input vec_t v);
        rstN = v.rstN; inValid = v.inV; rsAddr = v.rs; rtAddr = v.rt;
        useImm = v.useI; immVal = v.imm; aluControlIn = v.alu;
        destAddrIn = v.dest; regWriteIn = v.rw; wbEn = v.wbE;
        wbAddr = v.wbA; wbData = v.wbD; stall = v.st; flush = v.fl;
    endtask

    initial begin
        vec_t v;
        apply('0);
        //            rN iV rs rt uI imm            alu dst rw wE wA wD            st fl rdy val chk eA             eB             eAl eDs eRw
        vecs.push_back('{0, 0, 0, 0, 0, 0,             0, 0,  0, 0, 0, 0,             0, 0, 1, 0, 1, 0,             0,             0, 0,  0});
        vecs.push_back('{0, 0, 0, 0, 0, 0,             0, 0,  0, 1, 3, 32'h99,        0, 0, 1, 0, 1, 0,             0,             0, 0,  0});
        vecs.push_back('{1, 0, 0, 0, 0, 0,             0, 0,  0, 1, 5, 32'hAA,        0, 0, 1, 0, 0, 0,             0,             0, 0,  0});
        vecs.push_back('{1, 1, 5, 0, 0, 0,             2, 9,  1, 0, 0, 0,             0, 0, 1, 1, 1, 32'hAA,        0,             2, 9,  1});
        vecs.push_back('{1, 1, 7, 5, 0, 0,             1, 7,  0, 1, 7, 32'h12345678,  0, 0, 1, 1, 1, 32'h12345678,  32'hAA,        1, 7,  0});
        vecs.push_back('{1, 1, 0, 7, 0, 0,             3, 1,  1, 0, 0, 0,             0, 0, 1, 1, 1, 0,             32'h12345678,  3, 1,  1});
        vecs.push_back('{1, 1, 0, 0, 0, 0,             4, 2,  0, 1, 0, 32'hFFFFFFFF,  0, 0, 1, 1, 1, 0,             0,             4, 2,  0});
        vecs.push_back('{1, 1, 3, 3, 0, 0,             6, 4,  1, 1, 3, 32'h55,        0, 0, 1, 1, 1, 32'h55,        32'h55,        6, 4,  1});
        vecs.push_back('{1, 1, 0, 3, 1, 32'hFFFFFFF0,  5, 11, 0, 0, 0, 0,             0, 0, 1, 1, 1, 0,             32'hFFFFFFF0,  5, 11, 0});
        vecs.push_back('{1, 1, 5, 7, 0, 0,             7, 10, 1, 1, 6, 32'h66,        1, 0, 0, 1, 1, 0,             32'hFFFFFFF0,  5, 11, 0});
        vecs.push_back('{1, 1, 6, 6, 0, 0,             1, 12, 1, 0, 0, 0,             1, 0, 0, 1, 1, 0,             32'hFFFFFFF0,  5, 11, 0});
        vecs.push_back('{1, 1, 5, 5, 1, 32'h1,         2, 13, 1, 0, 0, 0,             1, 0, 0, 1, 1, 0,             32'hFFFFFFF0,  5, 11, 0});
        vecs.push_back('{1, 1, 6, 5, 0, 0,             2, 12, 1, 0, 0, 0,             0, 0, 1, 1, 1, 32'h66,        32'hAA,        2, 12, 1});
        vecs.push_back('{1, 1, 5, 5, 0, 0,             3, 1,  1, 0, 0, 0,             1, 1, 0, 0, 0, 0,             0,             0, 0,  0});
        vecs.push_back('{1, 0, 0, 0, 0, 0,             0, 0,  0, 0, 0, 0,             1, 0, 1, 0, 0, 0,             0,             0, 0,  0});
        vecs.push_back('{1, 1, 3, 3, 1, 32'hFFFFFFF0,  5, 3,  1, 0, 0, 0,             0, 0, 1, 1, 1, 32'h55,        32'hFFFFFFF0,  5, 3,  1});
        vecs.push_back('{0, 1, 3, 3, 0, 0,             7, 7,  1, 1, 3, 32'h77,        0, 0, 1, 0, 1, 0,             0,             0, 0,  0});
        vecs.push_back('{1, 1, 3, 3, 0, 0,             1, 1,  0, 0, 0, 0,             0, 0, 1, 1, 1, 0,             0,             1, 1,  0});
        vecs.push_back('{1, 1, 5, 5, 0, 0,             2, 2,  1, 0, 0, 0,             0, 1, 1, 0, 0, 0,             0,             0, 0,  0});

        foreach (vecs[i]) begin
            v = vecs[i];
            apply(v);
            #1;
            chk($sformatf("vec%0d.inReady", i), 32'(inReady), 32'(v.eRdy));
            modelStep();
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.outValid", i), 32'(outValid), 32'(v.eVal));
            if (v.chkD) begin
                chk($sformatf("vec%0d.srcA", i), srcA, v.eA);
                chk($sformatf("vec%0d.srcB", i), srcB, v.eB);
                chk($sformatf("vec%0d.aluControl", i), 32'(aluControl), 32'(v.eAlu));
                chk($sformatf("vec%0d.destAddr", i), 32'(destAddr), 32'(v.eDest));
                chk($sformatf("vec%0d.regWrite", i), 32'(regWrite), 32'(v.eRw));
            end
        end

        for (int n = 0; n < 600; n++) begin
            rstN         = ($urandom_range(0, 49) != 0);
            inValid      = 1'($urandom_range(0, 3) != 0);
            rsAddr       = 5'($urandom_range(0, 7));
            rtAddr       = 5'($urandom_range(0, 7));
            useImm       = 1'($urandom_range(0, 1));
            immVal       = $urandom;
            aluControlIn = 3'($urandom_range(0, 7));
            destAddrIn   = 5'($urandom_range(0, 31));
            regWriteIn   = 1'($urandom_range(0, 1));
            wbEn         = 1'($urandom_range(0, 1));
            wbAddr       = 5'($urandom_range(0, 7));
            wbData       = $urandom;
            stall        = ($urandom_range(0, 9) < 3);
            flush        = ($urandom_range(0, 9) == 0);
            #1;
            chk("rnd.inReady", 32'(inReady), 32'(!stall || !mValid));
            modelStep();
            @(posedge clk);
            #1;
            chk("rnd.outValid", 32'(outValid), 32'(mValid));
            if (mKnown) begin
                chk("rnd.srcA", srcA, mA);
                chk("rnd.srcB", srcB, mB);
                chk("rnd.aluControl", 32'(aluControl), 32'(mAlu));
                chk("rnd.destAddr", 32'(destAddr), 32'(mDest));
                chk("rnd.regWrite", 32'(regWrite), 32'(mRw));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of register data, immediate and ALU operands.
REQ-002 Parameter REG_AW, default 5, SHALL set the register address width; the register file depth SHALL be 2**REG_AW.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rstN  in  1  reset, synchronous and active-low.
REQ-005 inValid  in  1  decode stage presents a valid instruction.
REQ-006 inReady  out  1  this block accepts the presented instruction this cycle.
REQ-007 rsAddr  in  REG_AW  source register for srcA.
REQ-008 rtAddr  in  REG_AW  source register for srcB when useImm=0.
REQ-009 immVal  in  DATA_W  sign-extended immediate from decode.
REQ-010 useImm  in  1  1 selects immVal as srcB; 0 selects register rtAddr.
REQ-011 aluControlIn  in  3  ALU operation code, passed through unchanged.
REQ-012 destAddrIn  in  REG_AW  destination register, passed through.
REQ-013 regWriteIn  in  1  instruction writes a register, passed through.
REQ-014 wbEn  in  1  writeback write enable.
REQ-015 wbAddr  in  REG_AW  writeback register address.
REQ-016 wbData  in  DATA_W  writeback data.
REQ-017 stall  in  1  downstream cannot take a new operand set this cycle.
REQ-018 flush  in  1  discard the held operand set.
REQ-019 outValid  out  1  the srcA/srcB/aluControl/destAddr/regWrite outputs are valid.
REQ-020 srcA, srcB  out  DATA_W each  registered ALU operands.
REQ-021 aluControl  out  3; destAddr  out  REG_AW; regWrite  out  1: registered pass-through fields.

Function
REQ-022 Register file: 2**REG_AW x DATA_W entries; entry wbAddr SHALL be written with wbData at the clock edge when wbEn=1 and wbAddr!=0.
REQ-023 Register 0 SHALL always read as 0; writes to it SHALL be ignored.
REQ-024 Reads SHALL be combinational with write-through bypass: if wbEn=1, wbAddr!=0 and wbAddr equals the read address, the read value SHALL be wbData.
REQ-025 inReady SHALL be combinational and equal to (!stall || !outValid); it SHALL NOT depend on inValid.
REQ-026 Priority at each clock edge SHALL be: reset > flush > load > hold.
REQ-027 flush=1 SHALL clear outValid to 0 at the edge, regardless of stall and inValid; the data outputs are don't-care while outValid=0.
REQ-028 Load occurs when inReady=1 and flush=0: outValid<=inValid; when inValid=1 all output fields SHALL capture in one cycle.
REQ-029 On load, srcA<=read(rsAddr), srcB<=useImm ? immVal : read(rtAddr), and aluControl, destAddr and regWrite SHALL capture their inputs.
REQ-030 Hold: with stall=1, outValid=1 and flush=0, all outputs SHALL stay unchanged.
REQ-031 Latency: inputs accepted at edge N SHALL appear on the outputs after edge N; throughput SHALL be one instruction per cycle when stall=0.
REQ-032 A writeback in the same cycle as a load SHALL be visible in the loaded operands (per REQ-024), and the write SHALL also commit to the array.
REQ-033 A writeback during a hold SHALL update the array only; the held srcA and srcB SHALL NOT change.

Reset
REQ-034 While rstN=0 at an edge: outValid=0; srcA, srcB, aluControl, destAddr and regWrite SHALL be 0; all register file entries SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL discard the held instruction and any same-cycle writeback.
REQ-036 In the cycle after rstN returns to 1, normal loading SHALL proceed.

Verification
REQ-037 Reset, then wb r5=0x0000_00AA, then present rs=5, rt=0, useImm=0, aluControlIn=010 -> next cycle srcA=0xAA, srcB=0, aluControl=010, outValid=1.
REQ-038 wbEn=1, wbAddr=7, wbData=0x1234_5678 in the same cycle as a load with rs=7 -> srcA=0x1234_5678, and a later read of r7 returns 0x1234_5678.
REQ-039 wbEn=1, wbAddr=0, wbData=0xFFFF_FFFF, then load rs=0 -> srcA=0.
REQ-040 outValid=1 with stall=1 for 3 cycles while inValid=1 and inputs vary -> outputs stay constant and inReady=0; stall falls -> new instruction loaded at the next edge.
REQ-041 stall=1 and flush=1 together with outValid=1 -> outValid=0 after the edge, and inReady=1 in the following cycle.
REQ-042 useImm=1, immVal=0xFFFF_FFF0, rt=3 (r3=0x55) -> srcB=0xFFFF_FFF0; rstN=0 for one cycle while outValid=1 -> all outputs 0 and a read of r3 returns 0.
